// File: rtl/fp_operand_issue.sv
// Issue stage in front of a non-pipelined FP adder: buffers operand pairs, resolves
// IEEE-754 special cases on a bypass path and issues normal pairs one at a time.
module fp_operand_issue #(
    parameter int FIFO_DEPTH    = 2,
    parameter int ADDER_LATENCY = 5
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] InA,
    input  logic [31:0] InB,
    output logic [31:0] AddendA,
    output logic [31:0] AddendB,
    output logic        Go,
    output logic        AdderResultValid,
    output logic        Busy,
    output logic        BypassValid,
    output logic [31:0] BypassResult,
    output logic        BypassZero,
    output logic        BypassInf,
    output logic        BypassNan
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(ADDER_LATENCY + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic        special;
        logic [31:0] result;
        logic        zero;
        logic        inf;
        logic        nan;
    } bypass_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    // Denormals count as zero (flush-to-zero).
    function automatic logic is_zero(input logic [31:0] x);
        return (x[30:23] == 8'h00);
    endfunction

    function automatic bypass_t classify(input logic [31:0] a, input logic [31:0] b);
        bypass_t r;
        r = '0;
        if (is_nan(a) || is_nan(b)) begin
            r.special = 1'b1;
            r.result  = QNAN;
            r.nan     = 1'b1;
        end else if (is_inf(a) && is_inf(b) && (a[31] != b[31])) begin
            r.special = 1'b1;
            r.result  = QNAN;
            r.nan     = 1'b1;
        end else if (is_inf(a)) begin
            r.special = 1'b1;
            r.result  = a;
            r.inf     = 1'b1;
        end else if (is_inf(b)) begin
            r.special = 1'b1;
            r.result  = b;
            r.inf     = 1'b1;
        end else if (is_zero(a) && is_zero(b)) begin
            r.special = 1'b1;
            r.result  = {a[31] & b[31], 31'd0};
            r.zero    = 1'b1;
        end else if (is_zero(a)) begin
            r.special = 1'b1;
            r.result  = b;
        end else if (is_zero(b)) begin
            r.special = 1'b1;
            r.result  = a;
        end else begin
            r = '0;
        end
        return r;
    endfunction

    logic [31:0]  fifo_a_r [FIFO_DEPTH];
    logic [31:0]  fifo_b_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      addend_a_r;
    logic [31:0]      addend_b_r;
    logic             go_r;
    logic             arv_r;
    logic             busy_r;
    logic             bv_r;
    logic [31:0]      bres_r;
    logic             bzero_r;
    logic             binf_r;
    logic             bnan_r;

    logic    full_s;
    logic    empty_s;
    logic    push_s;
    logic    pop_s;
    bypass_t head_s;

    assign full_s  = (count_r == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty_s = (count_r == (PTR_W + 1)'(0));
    assign push_s  = InValid && !full_s;
    assign pop_s   = (state_r == ST_IDLE) && !empty_s;
    assign head_s  = classify(fifo_a_r[rd_ptr_r], fifo_b_r[rd_ptr_r]);

    // Operand FIFO storage, pointers and occupancy.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_a_r[i] <= 32'd0;
                fifo_b_r[i] <= 32'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                fifo_a_r[wr_ptr_r] <= InA;
                fifo_b_r[wr_ptr_r] <= InB;
                wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue FSM: bypass or issue the head in IDLE, count down the adder latency in WAIT.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            addend_a_r <= 32'd0;
            addend_b_r <= 32'd0;
            go_r       <= 1'b0;
            arv_r      <= 1'b0;
            busy_r     <= 1'b0;
            bv_r       <= 1'b0;
            bres_r     <= 32'd0;
            bzero_r    <= 1'b0;
            binf_r     <= 1'b0;
            bnan_r     <= 1'b0;
        end else begin
            go_r  <= 1'b0;
            arv_r <= 1'b0;
            bv_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        if (head_s.special) begin
                            bv_r    <= 1'b1;
                            bres_r  <= head_s.result;
                            bzero_r <= head_s.zero;
                            binf_r  <= head_s.inf;
                            bnan_r  <= head_s.nan;
                        end else begin
                            addend_a_r <= fifo_a_r[rd_ptr_r];
                            addend_b_r <= fifo_b_r[rd_ptr_r];
                            go_r       <= 1'b1;
                            busy_r     <= 1'b1;
                            cnt_r      <= CNT_W'(ADDER_LATENCY);
                            state_r    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Leaving at cnt==1 puts AdderResultValid in cycle Go+ADDER_LATENCY.
                    if (cnt_r <= CNT_W'(1)) begin
                        cnt_r   <= '0;
                        arv_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign InReady          = !full_s;
    assign AddendA          = addend_a_r;
    assign AddendB          = addend_b_r;
    assign Go               = go_r;
    assign AdderResultValid = arv_r;
    assign Busy             = busy_r;
    assign BypassValid      = bv_r;
    assign BypassResult     = bres_r;
    assign BypassZero       = bzero_r;
    assign BypassInf        = binf_r;
    assign BypassNan        = bnan_r;

endmodule

// File: tb/tb_fp_operand_issue.sv
// Directed self-checking bench for fp_operand_issue (FIFO_DEPTH=2, ADDER_LATENCY=5).
module tb_fp_operand_issue;

    logic        Clock;
    logic        Reset_n;
    logic        InValid;
    logic        InReady;
    logic [31:0] InA;
    logic [31:0] InB;
    logic [31:0] AddendA;
    logic [31:0] AddendB;
    logic        Go;
    logic        AdderResultValid;
    logic        Busy;
    logic        BypassValid;
    logic [31:0] BypassResult;
    logic        BypassZero;
    logic        BypassInf;
    logic        BypassNan;

    fp_operand_issue #(.FIFO_DEPTH(2), .ADDER_LATENCY(5)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
        .InA(InA), .InB(InB), .AddendA(AddendA), .AddendB(AddendB), .Go(Go),
        .AdderResultValid(AdderResultValid), .Busy(Busy), .BypassValid(BypassValid),
        .BypassResult(BypassResult), .BypassZero(BypassZero), .BypassInf(BypassInf),
        .BypassNan(BypassNan)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int go_n = 0, arv_n = 0, bv_n = 0, busy_n = 0, overlap_n = 0, stable_err = 0, rdy_low_n = 0;
    int go_cyc [64];
    logic [31:0] go_a [64];
    logic [31:0] go_b [64];
    int arv_cyc = 0, bv_cyc = 0;
    logic [31:0] bv_res = 32'd0;
    logic [2:0]  bv_flags = 3'd0;
    logic [31:0] cur_a = 32'd0, cur_b = 32'd0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Cycle index, advanced on every rising edge.
    always @(posedge Clock) cyc <= cyc + 1;

    // Event monitor sampling all outputs on the falling edge.
    always @(negedge Clock) begin
        if (Reset_n) begin
            if (Go) begin
                if (go_n < 64) begin
                    go_cyc[go_n] <= cyc;
                    go_a[go_n]   <= AddendA;
                    go_b[go_n]   <= AddendB;
                end
                go_n  <= go_n + 1;
                cur_a <= AddendA;
                cur_b <= AddendB;
            end else if (Busy || AdderResultValid) begin
                if (AddendA !== cur_a || AddendB !== cur_b) stable_err <= stable_err + 1;
            end
            if (AdderResultValid) begin
                arv_n   <= arv_n + 1;
                arv_cyc <= cyc;
            end
            if (BypassValid) begin
                bv_n     <= bv_n + 1;
                bv_cyc   <= cyc;
                bv_res   <= BypassResult;
                bv_flags <= {BypassZero, BypassInf, BypassNan};
                if (Busy) overlap_n <= overlap_n + 1;
            end
            if (Busy) busy_n <= busy_n + 1;
            if (!InReady) rdy_low_n <= rdy_low_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Offer one pair starting at a falling edge; returns the cycle ending in the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, output int acc);
        InValid = 1'b1;
        InA     = a;
        InB     = b;
        acc     = -1;
        for (int i = 0; i < 40; i++) begin
            if (InReady) begin
                acc = cyc;
                @(posedge Clock);
                @(negedge Clock);
                break;
            end
            @(negedge Clock);
        end
        if (acc < 0) chk("send_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vr [8];
    logic [2:0]  vf [8];

    initial begin
        int acc, acc2, acc3, gb, bb, ob, xb, sb, rb, ab;
        va[0] = 32'h7FC00001; vb[0] = 32'h3F800000; vr[0] = 32'h7FC00000; vf[0] = 3'b001;
        va[1] = 32'h7F800000; vb[1] = 32'hFF800000; vr[1] = 32'h7FC00000; vf[1] = 3'b001;
        va[2] = 32'h7F800000; vb[2] = 32'h3F800000; vr[2] = 32'h7F800000; vf[2] = 3'b010;
        va[3] = 32'h80000000; vb[3] = 32'h80000000; vr[3] = 32'h80000000; vf[3] = 3'b100;
        va[4] = 32'h00000000; vb[4] = 32'h80000000; vr[4] = 32'h00000000; vf[4] = 3'b100;
        va[5] = 32'h00000001; vb[5] = 32'h40400000; vr[5] = 32'h40400000; vf[5] = 3'b000;
        va[6] = 32'hFF800000; vb[6] = 32'h00000000; vr[6] = 32'hFF800000; vf[6] = 3'b010;
        va[7] = 32'h3F800000; vb[7] = 32'hFF800001; vr[7] = 32'h7FC00000; vf[7] = 3'b001;

        Reset_n = 1'b1;
        InValid = 1'b0;
        InA     = 32'd0;
        InB     = 32'd0;
        #1 Reset_n = 1'b0;
        repeat (2) @(negedge Clock);
        chk("rst_pulses", 32'({Go, AdderResultValid, Busy, BypassValid}), 32'd0);
        chk("rst_flags", 32'({BypassZero, BypassInf, BypassNan}), 32'd0);
        chk("rst_ready", 32'(InReady), 32'd1);
        chk("rst_addend_a", AddendA, 32'd0);
        chk("rst_addend_b", AddendB, 32'd0);
        chk("rst_bres", BypassResult, 32'd0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clock);

        // Normal issue
        gb = go_n; ab = arv_n; bb = bv_n; xb = busy_n; sb = stable_err;
        send(32'h3F800000, 32'h40000000, acc);
        InValid = 1'b0;
        repeat (12) @(negedge Clock);
        chk("norm_go_count", 32'(go_n - gb), 32'd1);
        chk("norm_go_lat", 32'(go_cyc[gb] - acc), 32'd2);
        chk("norm_addend_a", go_a[gb], 32'h3F800000);
        chk("norm_addend_b", go_b[gb], 32'h40000000);
        chk("norm_busy_len", 32'(busy_n - xb), 32'd5);
        chk("norm_arv_count", 32'(arv_n - ab), 32'd1);
        chk("norm_arv_lat", 32'(arv_cyc - go_cyc[gb]), 32'd5);
        chk("norm_no_bypass", 32'(bv_n - bb), 32'd0);
        chk("norm_stable", 32'(stable_err - sb), 32'd0);

        // Special-case bypass vectors
        for (int k = 0; k < 8; k++) begin
            gb = go_n; bb = bv_n;
            send(va[k], vb[k], acc);
            InValid = 1'b0;
            repeat (4) @(negedge Clock);
            chk($sformatf("byp%0d_count", k), 32'(bv_n - bb), 32'd1);
            chk($sformatf("byp%0d_nogo", k), 32'(go_n - gb), 32'd0);
            chk($sformatf("byp%0d_result", k), bv_res, vr[k]);
            chk($sformatf("byp%0d_flags", k), 32'(bv_flags), 32'(vf[k]));
            if (k == 0) chk("byp_latency", 32'(bv_cyc - acc), 32'd2);
        end
        chk("byp_hold", BypassResult, vr[7]);

        // Backpressure: three normal pairs with InValid held high
        gb = go_n; rb = rdy_low_n; sb = stable_err;
        send(32'h3F800000, 32'h40000000, acc);
        send(32'h40400000, 32'h40800000, acc2);
        send(32'hC0A00000, 32'h3F000000, acc3);
        InValid = 1'b0;
        repeat (30) @(negedge Clock);
        chk("bp_ready_low", 32'((rdy_low_n - rb) > 0), 32'd1);
        chk("bp_ready_back", 32'(InReady), 32'd1);
        chk("bp_go_count", 32'(go_n - gb), 32'd3);
        chk("bp_go_gap1", 32'(go_cyc[gb+1] - go_cyc[gb]), 32'd6);
        chk("bp_go_gap2", 32'(go_cyc[gb+2] - go_cyc[gb+1]), 32'd6);
        chk("bp_order_a0", go_a[gb], 32'h3F800000);
        chk("bp_order_a1", go_a[gb+1], 32'h40400000);
        chk("bp_order_b1", go_b[gb+1], 32'h40800000);
        chk("bp_order_a2", go_a[gb+2], 32'hC0A00000);
        chk("bp_order_b2", go_b[gb+2], 32'h3F000000);
        chk("bp_stable", 32'(stable_err - sb), 32'd0);

        // Ordering: bypass queued behind a normal pair
        bb = bv_n; ob = overlap_n;
        send(32'h3F800000, 32'h40000000, acc);
        send(32'h7FC00000, 32'h00000000, acc2);
        InValid = 1'b0;
        repeat (12) @(negedge Clock);
        chk("ord_bv_count", 32'(bv_n - bb), 32'd1);
        chk("ord_after_arv", 32'(bv_cyc - arv_cyc), 32'd1);
        chk("ord_no_overlap", 32'(overlap_n - ob), 32'd0);
        chk("ord_result", bv_res, 32'h7FC00000);

        // Reset during WAIT with a second pair still queued
        send(32'h3F800000, 32'h40000000, acc);
        send(32'h40400000, 32'h40800000, acc2);
        InValid = 1'b0;
        acc3 = 0;
        for (int i = 0; i < 10; i++) begin
            if (Go) begin
                acc3 = 1;
                break;
            end
            @(negedge Clock);
        end
        chk("rw_go_seen", 32'(acc3), 32'd1);
        repeat (2) @(negedge Clock);
        chk("rw_busy_before", 32'(Busy), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("rw_pulses", 32'({Go, AdderResultValid, Busy}), 32'd0);
        chk("rw_ready", 32'(InReady), 32'd1);
        chk("rw_addend", AddendA, 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
        gb = go_n; ab = arv_n; bb = bv_n;
        repeat (15) @(negedge Clock);
        chk("rw_no_go", 32'(go_n - gb), 32'd0);
        chk("rw_no_arv", 32'(arv_n - ab), 32'd0);
        chk("rw_no_bv", 32'(bv_n - bb), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
